// File: rtl/pipelined_alu_unit.sv
// Fully pipelined integer ALU with tag pass-through and a credit-protected in-order result buffer.
// Results appear LATENCY-1 edges after acceptance; flush or reset squashes everything in flight.
module pipelined_alu_unit #(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 3,
  parameter int TAG_WIDTH = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           valid_in,
  input  logic [WIDTH-1:0]               rval1_in,
  input  logic [WIDTH-1:0]               rval2_in,
  input  logic [3:0]                     aluFunc_in,
  input  logic [TAG_WIDTH-1:0]           rob_idx_in,
  input  logic                           flush_in,
  input  logic                           read_in,
  output logic                           ready_out,
  output logic                           valid_out,
  output logic [WIDTH-1:0]               data_out,
  output logic [TAG_WIDTH-1:0]           rob_idx_out,
  output logic [$clog2(OUT_DEPTH+1)-1:0] occupancy_out
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

  logic [WIDTH-1:0] alu_result;
  logic [SH_W-1:0]  shamt;
  logic             accept;
  logic             pop;

  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic [TAG_WIDTH-1:0] wr_tag;

  logic [CNT_W-1:0] occ_reg;
  logic [CNT_W-1:0] buf_count_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [WIDTH-1:0]     buf_data_mem [OUT_DEPTH];
  logic [TAG_WIDTH-1:0] buf_tag_mem  [OUT_DEPTH];

  always_comb begin
    alu_result = '0;
    shamt      = rval2_in[SH_W-1:0];
    case (aluFunc_in)
      4'd0: alu_result = rval1_in + rval2_in;
      4'd1: alu_result = rval1_in - rval2_in;
      4'd2: alu_result = rval1_in & rval2_in;
      4'd3: alu_result = rval1_in | rval2_in;
      4'd4: alu_result = rval1_in ^ rval2_in;
      4'd5: alu_result = {{(WIDTH-1){1'b0}}, ($signed(rval1_in) < $signed(rval2_in))};
      4'd6: alu_result = {{(WIDTH-1){1'b0}}, (rval1_in < rval2_in)};
      4'd7: alu_result = rval1_in << shamt;
      4'd8: alu_result = rval1_in >> shamt;
      4'd9: alu_result = $unsigned($signed(rval1_in) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  assign ready_out = (occ_reg < DEPTH_C);
  assign accept    = valid_in && ready_out;
  assign pop       = read_in && valid_out;

  generate
    if (LATENCY == 1) begin : g_direct
      assign wr_valid = accept;
      assign wr_data  = alu_result;
      assign wr_tag   = rob_idx_in;
    end else begin : g_pipe
      localparam int NSTG = LATENCY - 1;
      logic                 stage_valid_reg [NSTG];
      logic [WIDTH-1:0]     stage_data_reg  [NSTG];
      logic [TAG_WIDTH-1:0] stage_tag_reg   [NSTG];

      // Payload registers carry no reset; only the valids decide what reaches the buffer.
      always_ff @(posedge clk_in) begin
        stage_data_reg[0] <= alu_result;
        stage_tag_reg[0]  <= rob_idx_in;
        for (int i = 1; i < NSTG; i++) begin
          stage_data_reg[i] <= stage_data_reg[i-1];
          stage_tag_reg[i]  <= stage_tag_reg[i-1];
        end
        if (rst_in || flush_in) begin
          for (int i = 0; i < NSTG; i++) stage_valid_reg[i] <= 1'b0;
        end else begin
          stage_valid_reg[0] <= accept;
          for (int i = 1; i < NSTG; i++) stage_valid_reg[i] <= stage_valid_reg[i-1];
        end
      end

      assign wr_valid = stage_valid_reg[NSTG-1];
      assign wr_data  = stage_data_reg[NSTG-1];
      assign wr_tag   = stage_tag_reg[NSTG-1];
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        buf_data_mem[i] <= '0;
        buf_tag_mem[i]  <= '0;
      end
    end else if (wr_valid && !flush_in) begin
      buf_data_mem[tail_reg] <= wr_data;
      buf_tag_mem[tail_reg]  <= wr_tag;
    end
  end

  // Credits guarantee a free slot for every write, so no full check is needed here.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      buf_count_reg <= '0;
    end else begin
      if (wr_valid) tail_reg <= ptr_inc(tail_reg);
      if (pop)      head_reg <= ptr_inc(head_reg);
      case ({wr_valid, pop})
        2'b10:   buf_count_reg <= buf_count_reg + 1'b1;
        2'b01:   buf_count_reg <= buf_count_reg - 1'b1;
        default: buf_count_reg <= buf_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      occ_reg <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign valid_out     = (buf_count_reg != '0);
  assign data_out      = buf_data_mem[head_reg];
  assign rob_idx_out   = buf_tag_mem[head_reg];
  assign occupancy_out = occ_reg;

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// Randomized and directed bench for pipelined_alu_unit against a queue-based timing/result model.
module tb_pipelined_alu_unit;
  localparam int WIDTH = 32, LATENCY = 3, TAG_WIDTH = 3, OUT_DEPTH = 4;
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);
  localparam logic [31:0] T2_EXP [6] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'hF800_0000, 32'h0800_0000, 32'h2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in = 1'b1, valid_in = 1'b0, flush_in = 1'b0, read_in = 1'b0;
  logic [31:0] rval1_in = '0, rval2_in = '0;
  logic [3:0]  aluFunc_in = '0;
  logic [2:0]  rob_idx_in = '0;
  logic        ready_out, valid_out;
  logic [31:0] data_out;
  logic [2:0]  rob_idx_out;
  logic [OCC_W-1:0] occupancy_out;

  pipelined_alu_unit #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_WIDTH(TAG_WIDTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .rval1_in(rval1_in), .rval2_in(rval2_in),
    .aluFunc_in(aluFunc_in), .rob_idx_in(rob_idx_in), .flush_in(flush_in), .read_in(read_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out), .rob_idx_out(rob_idx_out),
    .occupancy_out(occupancy_out)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  tag;
    int          vis;
  } exp_t;

  exp_t        q[$];
  logic [31:0] popped_q[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Results from the arithmetic definitions using 64-bit integers.
  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p2, r;
    ua = longint'(64'(a));
    ub = longint'(64'(b));
    sa = ua >= 64'h8000_0000 ? ua - 64'h1_0000_0000 : ua;
    sb = ub >= 64'h8000_0000 ? ub - 64'h1_0000_0000 : ub;
    p2 = longint'(1) << (ub % 32);
    case (f)
      4'd0: r = ua + ub;
      4'd1: r = ua - ub;
      4'd2: r = longint'(64'(a & b));
      4'd3: r = longint'(64'(a | b));
      4'd4: r = longint'(64'(a ^ b));
      4'd5: r = (sa < sb) ? 1 : 0;
      4'd6: r = (ua < ub) ? 1 : 0;
      4'd7: r = ua * p2;
      4'd8: r = ua / p2;
      4'd9: r = (sa >= 0) ? sa / p2 : -(((-sa) + p2 - 1) / p2);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].vis <= cyc);
  endfunction

  task automatic check_outputs();
    chk("ready", 64'(ready_out), 64'(q.size() < OUT_DEPTH));
    chk("occupancy", 64'(occupancy_out), 64'(q.size()));
    chk("valid", 64'(valid_out), 64'(m_valid()));
    if (m_valid()) begin
      chk("data", 64'(data_out), 64'(q[0].data));
      chk("tag", 64'(rob_idx_out), 64'(q[0].tag));
    end
  endtask

  task automatic step(input bit v, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] t, input bit rd, input bit fl, input bit rs);
    exp_t e;
    bit acc, pp;
    logic [31:0] seen_data;
    logic [2:0]  seen_tag;
    valid_in = v; aluFunc_in = f; rval1_in = a; rval2_in = b; rob_idx_in = t;
    read_in = rd; flush_in = fl; rst_in = rs;
    acc = v && (q.size() < OUT_DEPTH);
    pp  = rd && m_valid();
    e.data = ref_alu(f, a, b);
    e.tag  = t;
    seen_data = data_out;
    seen_tag  = rob_idx_out;
    @(posedge clk);
    #1;
    cyc++;
    if (rs || fl) begin
      q.delete();
    end else begin
      if (pp) begin
        $display("pop cycle=%0d tag=%0d data=0x%08h", cyc, seen_tag, seen_data);
        popped_q.push_back(seen_data);
        void'(q.pop_front());
      end
      if (acc) begin
        e.vis = cyc + LATENCY - 1;
        q.push_back(e);
      end
    end
    check_outputs();
  endtask

  task automatic op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic [2:0] t, input bit rd);
    step(1'b1, f, a, b, t, rd, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, rd, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " ready"}, 64'(ready_out), 64'd1);
    chk({name, " valid"}, 64'(valid_out), 64'd0);
    chk({name, " occ"}, 64'(occupancy_out), 64'd0);
    chk({name, " data"}, 64'(data_out), 64'd0);
    chk({name, " tag"}, 64'(rob_idx_out), 64'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check_reset_state("reset");

    // Single add, visible on the third cycle after acceptance.
    op(4'd0, 32'd5, 32'd7, 3'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t1 valid", 64'(valid_out), 64'd1);
    chk("t1 data", 64'(data_out), 64'd12);
    chk("t1 tag", 64'(rob_idx_out), 64'd3);
    idle(1'b1);
    chk("t1 occ", 64'(occupancy_out), 64'd0);

    // Back-to-back mixed ops with continuous reads.
    popped_q.delete();
    op(4'd1, 32'h0, 32'h1, 3'd0, 1'b1);
    op(4'd5, 32'hFFFF_FFFF, 32'h1, 3'd1, 1'b1);
    op(4'd6, 32'hFFFF_FFFF, 32'h1, 3'd2, 1'b1);
    op(4'd9, 32'h8000_0000, 32'd4, 3'd3, 1'b1);
    op(4'd8, 32'h8000_0000, 32'd4, 3'd4, 1'b1);
    op(4'd7, 32'h1, 32'd33, 3'd5, 1'b1);
    repeat (4) idle(1'b1);
    chk("t2 count", 64'(popped_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped_q.size(); i++) chk("t2 result", 64'(popped_q[i]), 64'(T2_EXP[i]));

    // Fill with reads held off; ops 5 and 6 are refused.
    for (int i = 0; i < 6; i++) op(4'd0, 32'(i), 32'd100, 3'(i), 1'b0);
    chk("t3 occ full", 64'(occupancy_out), 64'd4);
    chk("t3 ready full", 64'(ready_out), 64'd0);
    idle(1'b1);
    chk("t3 ready after pop", 64'(ready_out), 64'd1);

    // Full buffer: offer plus pop in one cycle only pops.
    op(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6, 1'b0);
    repeat (3) idle(1'b0);
    op(4'd3, 32'h1234_0000, 32'h0000_5678, 3'd7, 1'b1);
    chk("t4 occ pop only", 64'(occupancy_out), 64'd3);
    idle(1'b1);
    op(4'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 3'd1, 1'b1);
    chk("t4 occ accept+pop", 64'(occupancy_out), 64'd2);
    repeat (6) idle(1'b1);

    // Flush with one buffered and two in flight, plus an offered op.
    op(4'd0, 32'd1, 32'd1, 3'd1, 1'b0);
    op(4'd0, 32'd2, 32'd2, 3'd2, 1'b0);
    op(4'd0, 32'd3, 32'd3, 3'd3, 1'b0);
    step(1'b1, 4'd0, 32'd4, 32'd4, 3'd4, 1'b0, 1'b1, 1'b0);
    chk("t5 valid", 64'(valid_out), 64'd0);
    chk("t5 occ", 64'(occupancy_out), 64'd0);
    chk("t5 ready", 64'(ready_out), 64'd1);
    repeat (5) idle(1'b1);

    // Undefined function code, then reset mid-pipeline.
    op(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 3'd5, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("t6 op12 data", 64'(data_out), 64'd0);
    chk("t6 op12 tag", 64'(rob_idx_out), 64'd5);
    op(4'd0, 32'd9, 32'd9, 3'd2, 1'b0);
    step(1'b1, 4'd0, 32'd1, 32'd1, 3'd6, 1'b1, 1'b0, 1'b1);
    check_reset_state("t6 reset");
    repeat (5) idle(1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
           3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (8) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
